// File: rtl/syncfifo_pkg.sv
// Shared pointer arithmetic for the synchronous FIFO write and read pointer stages.
// Pointers carry a wrap bit in the MSB; helpers work on zero-extended values.
package syncfifo_pkg;

  localparam int unsigned PTR_MAX_W = 32;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ACCEPT,
    WR_REJECT
  } wr_kind_e;

  function automatic int unsigned ptr_width_for(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] ptr_mask(input int unsigned pw);
    return (pw >= PTR_MAX_W) ? '1 : ((PTR_MAX_W'(1) << pw) - PTR_MAX_W'(1));
  endfunction

  function automatic logic [PTR_MAX_W-1:0] ptr_count(input logic [PTR_MAX_W-1:0] w,
                                                     input logic [PTR_MAX_W-1:0] r,
                                                     input int unsigned pw);
    return (w - r) & ptr_mask(pw);
  endfunction

  // Full when only the wrap bit differs.
  function automatic logic ptr_full(input logic [PTR_MAX_W-1:0] w,
                                    input logic [PTR_MAX_W-1:0] r,
                                    input int unsigned pw);
    return ((w ^ r) & ptr_mask(pw)) == (PTR_MAX_W'(1) << (pw - 1));
  endfunction

endpackage

// File: rtl/sync_fifo_write_ctrl_status.sv
// Combinational occupancy, full and almost-full decode from the two pointers.
module syncfifo_status
  import syncfifo_pkg::*;
#(
  parameter int unsigned depth     = 16,
  parameter int unsigned ptr_width = ptr_width_for(depth),
  parameter int unsigned af_margin = 2
) (
  input  logic [ptr_width-1:0] w_ptr,
  input  logic [ptr_width-1:0] r_ptr,
  output logic [ptr_width-1:0] count,
  output logic                 full,
  output logic                 almost_full
);

  localparam int unsigned CW = ptr_width + 1;

  logic [CW-1:0] free;

  always_comb begin
    count       = ptr_width'(ptr_count(PTR_MAX_W'(w_ptr), PTR_MAX_W'(r_ptr), ptr_width));
    full        = ptr_full(PTR_MAX_W'(w_ptr), PTR_MAX_W'(r_ptr), ptr_width);
    free        = CW'(depth) - {1'b0, count};
    almost_full = (free <= CW'(af_margin));
  end

endmodule

// File: rtl/sync_fifo_write_ctrl.sv
// Write-side pointer, overflow and status controller for the synchronous FIFO.
// Optional high-water mark register and ports are enabled by SYNCFIFO_HWM_EN.
module sync_fifo_write_ctrl
  import syncfifo_pkg::*;
#(
  parameter int unsigned depth     = 16,
  parameter int unsigned ptr_width = ptr_width_for(depth),
  parameter int unsigned af_margin = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wen,
  input  logic [ptr_width-1:0] r_ptr,
  output logic [ptr_width-1:0] w_ptr,
  output logic                 mem_wen,
  output logic [ptr_width-2:0] mem_waddr,
  output logic                 full,
  output logic                 almost_full,
  output logic [ptr_width-1:0] count,
  output logic                 overflow,
  input  logic                 ovf_clr
`ifdef SYNCFIFO_HWM_EN
  ,
  output logic [ptr_width-1:0] hwm,
  input  logic                 hwm_clr
`endif
);

  wr_kind_e             wr_kind;
  logic [ptr_width-1:0] w_ptr_next;

  syncfifo_status #(
    .depth    (depth),
    .ptr_width(ptr_width),
    .af_margin(af_margin)
  ) u_status (
    .w_ptr      (w_ptr),
    .r_ptr      (r_ptr),
    .count      (count),
    .full       (full),
    .almost_full(almost_full)
  );

  always_comb begin
    wr_kind = WR_IDLE;
    if (wen) wr_kind = full ? WR_REJECT : WR_ACCEPT;
    w_ptr_next = (wr_kind == WR_ACCEPT) ? w_ptr + ptr_width'(1) : w_ptr;
  end

  assign mem_wen   = (wr_kind == WR_ACCEPT);
  assign mem_waddr = w_ptr[ptr_width-2:0];

  // A rejected write takes priority over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr    <= '0;
      overflow <= 1'b0;
    end else begin
      w_ptr <= w_ptr_next;
      if (wr_kind == WR_REJECT) overflow <= 1'b1;
      else if (ovf_clr)         overflow <= 1'b0;
    end
  end

`ifdef SYNCFIFO_HWM_EN
  logic [ptr_width-1:0] count_next;

  always_comb begin
    count_next = ptr_width'(ptr_count(PTR_MAX_W'(w_ptr_next), PTR_MAX_W'(r_ptr), ptr_width));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  hwm <= '0;
    else if (hwm_clr)            hwm <= count_next;
    else if (count_next > hwm)   hwm <= count_next;
  end
`endif

endmodule

// File: tb/tb_sync_fifo_write_ctrl.sv
// Self-checking bench for sync_fifo_write_ctrl: vector table, corner sequences, random traffic.
// The read-pointer stage is modelled here; SYNCFIFO_HWM_EN adds high-water mark checks.
module tb_sync_fifo_write_ctrl;

  localparam int DEPTH = 16;
  localparam int PW    = 5;
  localparam int AFM   = 2;
  localparam int PMOD  = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wen = 1'b0;
  logic [PW-1:0] r_ptr = '0;
  logic [PW-1:0] w_ptr;
  logic          mem_wen;
  logic [PW-2:0] mem_waddr;
  logic          full, almost_full, overflow;
  logic [PW-1:0] count;
  logic          ovf_clr = 1'b0;
`ifdef SYNCFIFO_HWM_EN
  logic [PW-1:0] hwm;
  logic          hwm_clr = 1'b0;
`endif

  sync_fifo_write_ctrl #(.depth(DEPTH), .af_margin(AFM)) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .r_ptr(r_ptr), .w_ptr(w_ptr),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .full(full), .almost_full(almost_full),
    .count(count), .overflow(overflow), .ovf_clr(ovf_clr)
`ifdef SYNCFIFO_HWM_EN
    , .hwm(hwm), .hwm_clr(hwm_clr)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: occupancy and transfer totals, not pointers.
  int occ = 0, wr_total = 0, rd_total = 0, m_hwm = 0;
  bit m_ovf = 0;
  bit saw_full_in_wrap = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_state();
    chk("w_ptr", int'(w_ptr), wr_total % PMOD);
    chk("count", int'(count), occ);
    chk("full", int'(full), int'(occ == DEPTH));
    chk("almost_full", int'(almost_full), int'((DEPTH - occ) <= AFM));
    chk("overflow", int'(overflow), int'(m_ovf));
`ifdef SYNCFIFO_HWM_EN
    chk("hwm", int'(hwm), m_hwm);
`endif
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input bit w, input bit r, input bit oc, input bit hc);
    bit acc, rej, rd_ok;
    int cn;
    wen = w; ovf_clr = oc;
`ifdef SYNCFIFO_HWM_EN
    hwm_clr = hc;
`endif
    #1;
    acc   = w && (occ < DEPTH);
    rej   = w && (occ == DEPTH);
    rd_ok = r && (occ > 0);
    chk("mem_wen", int'(mem_wen), int'(acc));
    chk("mem_waddr", int'(mem_waddr), wr_total % DEPTH);
    cn = occ + int'(acc);
    if (hc) m_hwm = cn;
    else if (cn > m_hwm) m_hwm = cn;
    if (rej) m_ovf = 1;
    else if (oc) m_ovf = 0;
    @(posedge clk);
    #1;
    if (acc) wr_total++;
    if (rd_ok) begin
      rd_total++;
      r_ptr = PW'(rd_total % PMOD);
    end
    occ = occ + int'(acc) - int'(rd_ok);
    @(negedge clk);
    wen = 0; ovf_clr = 0;
`ifdef SYNCFIFO_HWM_EN
    hwm_clr = 0;
`endif
    check_state();
  endtask

  // Reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    wen = 0; ovf_clr = 0;
    rst_n = 0;
    r_ptr = '0;
    #1;
    occ = 0; wr_total = 0; rd_total = 0; m_ovf = 0; m_hwm = 0;
    chk("rst_w_ptr", int'(w_ptr), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_mem_wen", int'(mem_wen), 0);
    chk("rst_almost_full", int'(almost_full), 0);
`ifdef SYNCFIFO_HWM_EN
    chk("rst_hwm", int'(hwm), 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  typedef struct {
    bit w; bit r; bit oc;
    int e_count; bit e_full; bit e_af; bit e_ovf;
  } vec_t;

  vec_t vt[$];

  initial begin
    // Fill, overflow, clear, read-at-full, refill.
    for (int i = 0; i < DEPTH; i++)
      vt.push_back('{1, 0, 0, i + 1, (i == DEPTH - 1), ((i + 1) >= DEPTH - AFM), 0});
    vt.push_back('{1, 0, 0, 16, 1, 1, 1});
    vt.push_back('{0, 0, 1, 16, 1, 1, 0});
    vt.push_back('{1, 1, 0, 15, 0, 1, 1});
    vt.push_back('{1, 0, 0, 16, 1, 1, 1});
    vt.push_back('{0, 1, 1, 15, 0, 1, 0});

    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check_state();

    foreach (vt[i]) begin
      cycle(vt[i].w, vt[i].r, vt[i].oc, 0);
      chk($sformatf("vec%0d_count", i), int'(count), vt[i].e_count);
      chk($sformatf("vec%0d_full", i), int'(full), int'(vt[i].e_full));
      chk($sformatf("vec%0d_af", i), int'(almost_full), int'(vt[i].e_af));
      chk($sformatf("vec%0d_ovf", i), int'(overflow), int'(vt[i].e_ovf));
      if (i == DEPTH - 1) chk("fill_w_ptr", int'(w_ptr), 16);
      if (i == DEPTH) chk("ovf_w_ptr_hold", int'(w_ptr), 16);
    end

    // Reset in the middle of a write burst.
    cycle(1, 0, 0, 0);
    wen = 1;
    do_reset();
    check_state();

    // Wrap: 40 writes and 40 reads with occupancy held at 3.
    repeat (3) cycle(1, 0, 0, 0);
    repeat (37) begin
      cycle(1, 1, 0, 0);
      if (full) saw_full_in_wrap = 1;
    end
    repeat (3) cycle(0, 1, 0, 0);
    chk("wrap_w_ptr", int'(w_ptr), 8);
    chk("wrap_count", int'(count), 0);
    chk("wrap_never_full", int'(saw_full_in_wrap), 0);

`ifdef SYNCFIFO_HWM_EN
    do_reset();
    repeat (9) cycle(1, 0, 0, 0);
    repeat (7) cycle(0, 1, 0, 0);
    chk("hwm_peak", int'(hwm), 9);
    cycle(0, 0, 0, 1);
    chk("hwm_clr", int'(hwm), 2);
`endif

    // Random traffic against the model, biased toward both full and empty regions.
    for (int ph = 0; ph < 4; ph++) begin
      for (int n = 0; n < 100; n++) begin
        int wp;
        wp = (ph % 2 == 0) ? 75 : 30;
        cycle($urandom_range(0, 99) < wp, $urandom_range(0, 99) < 50,
              $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 5);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
